// File: rtl/lsu_rmw_if.sv
// Core request/response handshake and data-memory bus of the load/store unit.
interface lsu_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // View of the load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
  );

  // View of the surroundings: the core issuing requests and the memory answering reads.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit driving a word-addressed single-port memory. All accesses are
// aligned 32-bit words; sub-word stores are done as read-modify-write.
module lsu_rmw #(
  parameter int MEM_WORDS   = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  lsu_rmw_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_buf;
  logic [1:0]  size;
  logic        we;
  logic        uns;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic        accept;
  logic        req_err;

  // Select the addressed byte/halfword lane and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = zext ? {24'd0, b} : 32'(b);
      2'b01:   r = zext ? {16'd0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the right-justified store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8]    = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Acceptance and error classification of the request currently offered.
  always_comb begin
    accept  = bus.req_valid && (state == IDLE);
    req_err = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
    if (CHECK_ALIGN) begin
      if ((bus.req_size == 2'b01) && bus.req_addr[0]) req_err = 1'b1;
      if (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00)) req_err = 1'b1;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: errors answer at once, word stores skip the read.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                         state_nx = RESP;
          else if (bus.req_we && bus.req_size[1]) state_nx = WR;
          else                                 state_nx = RD;
        end
      end
      RD:      state_nx = we ? WR : RESP;
      WR:      state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; mem_we clears asynchronously with the state.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.mem_we    = (state == WR);
    bus.mem_a     = {addr[31:2], 2'b00};
    bus.mem_wd    = merge_store(rd_buf, wdata, size, addr[1:0]);
    bus.rsp_err   = rsp_err_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

  // Request latches, read buffer and response registers (held between transactions).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      wdata       <= '0;
      rd_buf      <= '0;
      size        <= '0;
      we          <= 1'b0;
      uns         <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        size  <= bus.req_size;
        we    <= bus.req_we;
        uns   <= bus.req_unsigned;
      end
      if (state == RD) rd_buf <= bus.mem_rd;
      if (accept && req_err) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end else if (state == RD && !we) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= load_ext(bus.mem_rd, size, addr[1:0], uns);
      end else if (state == WR) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: behavioural memory plus a transaction-level expectation queue.
`timescale 1ns/1ps
module tb_lsu_rmw;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_rmw_if bus();

  lsu_rmw #(.MEM_WORDS(64), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Attached memory: combinational read, write on posedge; preload through poke.
  logic [31:0] mem [0:63];
  logic        poke = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
    else if (poke)  mem[poke_idx] <= poke_val;
  end

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic        is_wr;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:63];
  int          errors = 0;
  int          checks = 0;
  int          ncyc = 0;
  int          we_cnt = 0;
  int          resp_cnt = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'hFACEFACE;
      1:       return 32'h00000002;
      2:       return 32'h11223344;
      default: return 32'hA5000000 | 32'(i);
    endcase
  endfunction

  // Compare process: every cycle, DUT outputs against the expectation queue.
  always @(negedge clk) begin
    ncyc++;
    if (!chk_en) begin
      we_cnt = 0;
    end else begin
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_q.size() == 0});
      if (bus.mem_we) begin
        we_cnt++;
        if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
          chk("unexpected mem_we", 32'd1, 32'd0);
        end else begin
          chk("mem_a", bus.mem_a, exp_q[0].wa);
          chk("mem_wd", bus.mem_wd, exp_q[0].wd);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].due == ncyc) begin
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_q[0].err});
        chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        chk("mem_we cycles", 32'(we_cnt), exp_q[0].is_wr ? 32'd1 : 32'd0);
        if (exp_q[0].is_wr) chk("mem word after write", mem[exp_q[0].wa[7:2]], exp_q[0].wd);
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        we_cnt     = 0;
        resp_cnt++;
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid idle", {31'd0, bus.rsp_valid}, 32'd0);
      end
    end
  end

  // Issue one request; the model derives error, latency, load data and written word.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic wait_resp);
    exp_t        e;
    logic [31:0] w, v, m;
    int          sh, n, start;
    e.err = ((a >> 2) >= 32'd64) || (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    w = ref_mem[a[7:2]];
    sh = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    m = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    v = (w >> sh) & m;
    if (sz == 2'b00 && !uns && v[7])  v = v | 32'hFFFFFF00;
    if (sz == 2'b01 && !uns && v[15]) v = v | 32'hFFFF0000;
    if (sz[1]) v = w;
    e.rdata = (e.err || we) ? 32'd0 : v;
    e.is_wr = we && !e.err;
    e.wa    = {24'd0, a[7:2], 2'b00};
    e.wd    = sz[1] ? wd : ((w & ~(m << sh)) | ((wd & m) << sh));
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    e.due = ncyc + (e.err ? 1 : (!we ? 2 : (sz[1] ? 2 : 3)));
    exp_q.push_back(e);
    start = resp_cnt;
    #1;
    bus.req_valid = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~wd;
    bus.req_size = ~sz; bus.req_we = ~we; bus.req_unsigned = ~uns;
    if (wait_resp) begin
      n = 0;
      while (resp_cnt == start && n < 10) begin @(posedge clk); n++; end
      if (resp_cnt == start) begin
        chk("response timeout", 32'd0, 32'd1);
        exp_q.delete();
      end else if (e.is_wr) begin
        ref_mem[a[7:2]] = e.wd;
      end
    end
  endtask

  task automatic expect_last(input string name, input logic [31:0] rdata, input logic err);
    chk({name, " rdata"}, last_rdata, rdata);
    chk({name, " err"}, {31'd0, last_err}, {31'd0, err});
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    @(posedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      poke = 1'b1; poke_idx = 6'(i); poke_val = init_val(i); ref_mem[i] = init_val(i);
    end
    @(negedge clk);
    poke = 1'b0;
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset mem_a", bus.mem_a, 32'd0);
    chk("reset mem_wd", bus.mem_wd, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    issue(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 1'b1);  expect_last("lb a1", 32'hFFFFFFFA, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 1'b1);  expect_last("lbu a0", 32'h000000CE, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b1);  expect_last("lh a2", 32'hFFFFFACE, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 1'b1);  expect_last("lhu a2", 32'h0000FACE, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);  expect_last("lw a0", 32'hFACEFACE, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h123456AB, 1'b1);
    expect_last("sb a5", 32'h0, 1'b0);
    chk("word1 after sb", mem[1], 32'h0000AB02);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);  expect_last("lw a4", 32'h0000AB02, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h5678, 1'b1);
    expect_last("sh misaligned", 32'h0, 1'b1);
    chk("word0 unchanged", mem[0], 32'hFACEFACE);
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
    expect_last("sw out of range", 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'hFC, 32'hDEADBEEF, 1'b1);
    chk("word63 after sw", mem[63], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b1); expect_last("lw aFC", 32'hDEADBEEF, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234BEEF, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 1'b1);  expect_last("size3 a4", 32'hBEEFAB02, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b1);  expect_last("lb a7", 32'hFFFFFFBE, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 1'b1);  expect_last("lbu a6", 32'h000000EF, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 1'b1);  expect_last("lh a6", 32'hFFFFBEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 1'b1);  expect_last("lw misaligned", 32'h0, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1); expect_last("lb out of range", 32'h0, 1'b1);

    // Reset during the WR cycle of a byte store.
    issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h55, 1'b0);
    n = 0;
    while (!bus.mem_we && n < 10) begin @(posedge clk); #1; n++; end
    chk("mem_we reaches WR", {31'd0, bus.mem_we}, 32'd1);
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("mem_we async drop", {31'd0, bus.mem_we}, 32'd0);
    chk("rsp_valid in reset", {31'd0, bus.rsp_valid}, 32'd0);
    chk("req_ready in reset", {31'd0, bus.req_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rsp_valid held reset", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", {31'd0, bus.req_ready}, 32'd1);
    chk("word2 unchanged", mem[2], 32'h11223344);
    chk_en = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1);  expect_last("lw a8 after reset", 32'h11223344, 1'b0);

    @(negedge clk);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit: the initiator that drives the word-addressed, single-port data memory (combinational read, write on posedge clk when WE).
- Accepts byte, halfword and word load/store requests from the core through a valid/ready handshake.
- Performs all memory accesses as aligned 32-bit words. Sub-word stores use a read-modify-write sequence.
- Returns sign- or zero-extended load data, plus an error flag for misaligned or out-of-range accesses.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the attached memory. An access is in range when addr[31:2] < MEM_WORDS.
- CHECK_ALIGN, 1: 1 = misaligned halfword/word accesses are flagged as errors; 0 = addr[1:0] is ignored for word accesses and addr[0] for halfword accesses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit is idle and can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse marking request completion.
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range access.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_we  out  1  memory write enable.
- mem_a  out  32  memory byte address; always {addr[31:2],2'b00}.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_a.

Behaviour:
- Reset: asynchronous and active-high, as already decided.
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0.
  - Internal latches (addr, size, we, unsigned, wdata, rd_buf) clear to 0.
- FSM states: IDLE, RD, WR, RESP.
  - mem_we is decoded from state and is 1 only in WR.
- IDLE:
  - req_ready=1.
  - A request is accepted on the rising edge when req_valid && req_ready. All request fields are latched at acceptance; later changes on req_* are ignored.
  - Error check at acceptance: (CHECK_ALIGN && ((size==half && addr[0]) || (size==word && addr[1:0]!=0))) || addr[31:2] >= MEM_WORDS.
  - Error → RESP with err flag set; no memory access occurs.
  - Word store → WR.
  - Any load or sub-word store → RD.
- RD:
  - mem_a = aligned address, mem_we=0.
  - mem_rd is captured into rd_buf at the end of the cycle.
  - Load → RESP. Sub-word store → WR.
- WR:
  - mem_we=1, mem_a = aligned address.
  - Word store: mem_wd = wdata.
  - Byte store: mem_wd = rd_buf with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: mem_wd = rd_buf with halfword lane addr[1] replaced by wdata[15:0].
  - Next state → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err as latched.
  - rsp_rdata: loads take the lane selected from rd_buf, extended per the unsigned flag. Stores and errors give 0.
  - Next state → IDLE.
- Byte order: little-endian. Byte lane n is bits [8n+7:8n]; halfword lane h is bits [16h+15:16h].
- Latency from the acceptance edge to the rsp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: a new request can be accepted in the IDLE cycle immediately following RESP. No back-to-back acceptance while busy.
- Busy: req_ready=0 in RD, WR and RESP. A req_valid asserted while busy is neither sampled nor lost-tracked; the core must hold it.
- Reset mid-operation:
  - mem_we drops immediately (asynchronously).
  - The pending request is discarded with no rsp_valid.
  - A write already committed on an earlier edge stays in memory.
  - Reset asserted during RD of a sub-word store leaves memory unchanged.
- Outputs other than mem_* hold their values between transactions. mem_a and mem_wd are don't-care when mem_we=0, except mem_a in RD.

Test Plan:
- Memory preloaded with word0=0xFACEFACE. Signed byte load at addr 1 → rsp_valid two cycles after acceptance, rsp_rdata=0xFFFFFFFA, rsp_err=0. Unsigned byte load at addr 0 → 0x000000CE.
- Signed halfword load at addr 2 from word0 → 0xFFFFFACE. Unsigned halfword load at addr 2 → 0x0000FACE. Word load at addr 0 → 0xFACEFACE.
- word1=0x00000002; byte store at addr 5 with wdata 0x123456AB → sequence RD then WR, with mem_we high for exactly one cycle and mem_wd=0x0000AB02. A following word load at addr 4 → 0x0000AB02. rsp_valid arrives three cycles after acceptance.
- Halfword store at addr 3 with CHECK_ALIGN=1 → rsp_valid one cycle after acceptance with rsp_err=1. mem_we never asserts; word0 is unchanged.
- Word store at addr 0x100 with MEM_WORDS=64 → rsp_err=1 and no write. Word store of 0xDEADBEEF at addr 0xFC → word63=0xDEADBEEF.
- Reset asserted during the WR cycle of a byte store → mem_we falls without waiting for a clock edge; no rsp_valid; req_ready=1 after reset; target word unchanged.
